// File: rtl/uart_term_ctrl.sv
// Text-terminal controller: uart_rx byte stream -> character RAM writes,
// with cursor tracking, ESC attribute prefix, screen clear and echo FIFO.
module uart_term_ctrl #(
    parameter int          COLS       = 50,
    parameter int          ROWS       = 15,
    parameter logic [7:0]  ATTR_RST   = 8'hF0,
    parameter int          ECHO_DEPTH = 4
) (
    input  logic        clk_144m,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        rx_error,
    output logic        ram_ce,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        tx_busy,
    output logic [11:0] cursor,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(ECHO_DEPTH);

    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
    localparam logic [11:0]   CELL_MAX = 12'(COLS * ROWS - 1);
    localparam logic [11:0]   COLS_W   = 12'(COLS);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(ECHO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ESC   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    attr;
    logic [11:0]   clr_addr;
    logic          pend_valid;
    logic [7:0]    pend_byte;

    logic [7:0]    fifo [ECHO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [1:0]    holdoff;

    logic          acc;
    logic          in_clear;
    logic          proc_valid;
    logic [7:0]    cur_byte;
    logic          printable;
    logic          pend_drop;
    logic          pop;
    logic          push;
    logic          echo_drop;

    // Byte routing: a held byte is always serviced before a fresh one.
    always_comb begin
        acc        = rx_ready && !rx_error;
        in_clear   = (state == CLEAR);
        proc_valid = !in_clear && (pend_valid || acc);
        cur_byte   = pend_valid ? pend_byte : rx_data;
        printable  = (cur_byte >= 8'h20) && (cur_byte <= 8'h7E);
        pend_drop  = acc && in_clear && pend_valid;
        pop        = (count != '0) && !tx_busy && (holdoff == 2'd0);
        push       = acc && ((count != FIFO_FULL) || pop);
        echo_drop  = acc && !push;
    end

    // Terminal FSM: cursor, attribute, pending byte and RAM write port.
    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            cursor     <= '0;
            attr       <= ATTR_RST;
            clr_addr   <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            busy       <= 1'b0;
            ram_ce     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            ram_ce <= 1'b0;

            if (in_clear) begin
                if (acc && !pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_byte  <= rx_data;
                end
            end else if (pend_valid) begin
                pend_valid <= acc;
                if (acc) begin
                    pend_byte <= rx_data;
                end
            end

            unique case (state)
                IDLE: begin
                    if (proc_valid) begin
                        if (printable) begin
                            ram_ce   <= 1'b1;
                            ram_addr <= cursor;
                            ram_data <= {attr, cur_byte};
                            if (col == COL_MAX) begin
                                col <= '0;
                                if (row == ROW_MAX) begin
                                    row    <= '0;
                                    cursor <= '0;
                                end else begin
                                    row    <= row + RW'(1);
                                    cursor <= cursor + 12'd1;
                                end
                            end else begin
                                col    <= col + CW'(1);
                                cursor <= cursor + 12'd1;
                            end
                        end else if (cur_byte == 8'h0D) begin
                            col    <= '0;
                            cursor <= cursor - 12'(col);
                        end else if (cur_byte == 8'h0A) begin
                            if (row == ROW_MAX) begin
                                row    <= '0;
                                cursor <= 12'(col);
                            end else begin
                                row    <= row + RW'(1);
                                cursor <= cursor + COLS_W;
                            end
                        end else if (cur_byte == 8'h08) begin
                            if (col != '0) begin
                                col      <= col - CW'(1);
                                cursor   <= cursor - 12'd1;
                                ram_ce   <= 1'b1;
                                ram_addr <= cursor - 12'd1;
                                ram_data <= {attr, 8'h20};
                            end
                        end else if (cur_byte == 8'h0C) begin
                            state    <= CLEAR;
                            busy     <= 1'b1;
                            clr_addr <= '0;
                        end else if (cur_byte == 8'h1B) begin
                            state <= ESC;
                        end
                    end
                end
                ESC: begin
                    if (proc_valid) begin
                        attr  <= cur_byte;
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    ram_ce   <= 1'b1;
                    ram_addr <= clr_addr;
                    ram_data <= {ATTR_RST, 8'h20};
                    if (clr_addr == CELL_MAX) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        col    <= '0;
                        row    <= '0;
                        cursor <= '0;
                    end else begin
                        clr_addr <= clr_addr + 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Echo FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_144m) begin
        if (push) begin
            fifo[wr_ptr] <= rx_data;
        end
    end

    // Echo scheduling with a post-send holdoff, plus the drop indicator.
    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            holdoff  <= '0;
            tx_ready <= 1'b0;
            tx_data  <= '0;
            overrun  <= 1'b0;
        end else begin
            tx_ready <= pop;
            overrun  <= echo_drop || pend_drop;
            if (pop) begin
                tx_data <= fifo[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
                holdoff <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_term_ctrl.sv
// Bench for uart_term_ctrl: directed scenarios plus a random byte stream
// checked against a cell/row/column reference model.
`timescale 1ns/1ps
module tb_uart_term_ctrl;

    logic        clk_144m = 1'b0;
    logic        reset    = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_ready = 1'b0;
    logic        rx_error = 1'b0;
    logic        tx_busy  = 1'b0;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [11:0] cursor;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovc      = 0;

    logic [27:0] wq[$];
    int          wcyc[$];
    logic [7:0]  tq[$];
    int          tcyc[$];

    int          m_col;
    int          m_row;
    logic [7:0]  m_attr;
    bit          m_esc;
    logic [27:0] ew[$];
    logic [7:0]  et[$];

    uart_term_ctrl dut (
        .clk_144m (clk_144m),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .ram_ce   (ram_ce),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .cursor   (cursor),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk_144m = ~clk_144m;

    // Record RAM writes, echo sends and overrun pulses mid-cycle.
    always @(negedge clk_144m) begin
        cyc++;
        if (ram_ce) begin
            wq.push_back({ram_addr, ram_data});
            wcyc.push_back(cyc);
        end
        if (tx_ready) begin
            tq.push_back(tx_data);
            tcyc.push_back(cyc);
        end
        if (overrun) ovc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_144m);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, input logic err = 1'b0);
        @(posedge clk_144m);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        rx_error = err;
        @(posedge clk_144m);
        #1;
        rx_ready = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b, input logic err = 1'b0);
        strobe(b, err);
        idle(1);
    endtask

    task automatic clear_logs();
        wq.delete();
        wcyc.delete();
        tq.delete();
        tcyc.delete();
        ew.delete();
        et.delete();
    endtask

    task automatic model_init();
        m_col  = 0;
        m_row  = 0;
        m_attr = 8'hF0;
        m_esc  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        et.push_back(b);
        if (m_esc) begin
            m_attr = b;
            m_esc  = 0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            ew.push_back({12'(m_row * 50 + m_col), m_attr, b});
            m_col++;
            if (m_col == 50) begin
                m_col = 0;
                m_row = (m_row + 1) % 15;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = (m_row + 1) % 15;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                ew.push_back({12'(m_row * 50 + m_col), m_attr, 8'h20});
            end
        end else if (b == 8'h1B) begin
            m_esc = 1;
        end
    endtask

    task automatic do_reset();
        rx_ready = 1'b0;
        rx_error = 1'b0;
        tx_busy  = 1'b0;
        reset    = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        clear_logs();
        model_init();
        ovc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ram_ce !== 1'b0) begin
            n_fail++; $display("FAIL reset_ram_ce got %b exp 0", ram_ce);
        end
        n_checks++;
        if (ram_addr !== 12'd0) begin
            n_fail++; $display("FAIL reset_ram_addr got %0d exp 0", ram_addr);
        end
        n_checks++;
        if (ram_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_ram_data got %h exp 0", ram_data);
        end
        n_checks++;
        if (tx_ready !== 1'b0 || tx_data !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_tx got %b/%h exp 0/00", tx_ready, tx_data);
        end
        n_checks++;
        if (cursor !== 12'd0) begin
            n_fail++; $display("FAIL reset_cursor got %0d exp 0", cursor);
        end
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b/%b exp 0/0", busy, overrun);
        end
    endtask

    task automatic test_single_char();
        int k;
        do_reset();
        strobe(8'h41);
        n_checks++;
        if (ram_ce !== 1'b1 || ram_addr !== 12'd0) begin
            n_fail++;
            $display("FAIL char_write got ce=%b a=%0d exp ce=1 a=0", ram_ce, ram_addr);
        end
        n_checks++;
        if (ram_data !== 16'hF041) begin
            n_fail++; $display("FAIL char_data got %h exp F041", ram_data);
        end
        n_checks++;
        if (cursor !== 12'd1) begin
            n_fail++; $display("FAIL char_cursor got %0d exp 1", cursor);
        end
        k = 0;
        while (tq.size() == 0 && k < 20) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (tq.size() != 1) begin
            n_fail++; $display("FAIL char_echo_count got %0d exp 1", tq.size());
        end else if (tq[0] !== 8'h41) begin
            n_fail++; $display("FAIL char_echo_data got %h exp 41", tq[0]);
        end
    endtask

    task automatic test_wrap();
        int sent;
        logic [7:0] b;
        do_reset();
        sent = 0;
        repeat (50) begin send_gap(8'h78); sent++; end
        send_gap(8'h79); sent++;
        n_checks++;
        if (wq[$] !== {12'd50, 16'hF079} || cursor !== 12'd51) begin
            n_fail++;
            $display("FAIL wrap_row got %h cur=%0d exp 032F079 cur=51", wq[$], cursor);
        end
        send_gap(8'h0D); send_gap(8'h0A); sent += 2;
        n_checks++;
        if (cursor !== 12'd100) begin
            n_fail++; $display("FAIL wrap_crlf got %0d exp 100", cursor);
        end
        repeat (649) begin
            b = 8'($urandom_range(32, 126));
            send_gap(b);
            sent++;
        end
        n_checks++;
        if (cursor !== 12'd749) begin
            n_fail++; $display("FAIL wrap_fill got %0d exp 749", cursor);
        end
        send_gap(8'h65); sent++;
        n_checks++;
        if (wq[$] !== {12'd749, 16'hF065} || cursor !== 12'd0) begin
            n_fail++;
            $display("FAIL wrap_last got %h cur=%0d exp 2EDF065 cur=0", wq[$], cursor);
        end
        send_gap(8'h66); sent++;
        n_checks++;
        if (wq[$] !== {12'd0, 16'hF066}) begin
            n_fail++; $display("FAIL wrap_zero got %h exp 000F066", wq[$]);
        end
        idle(10);
        n_checks++;
        if (tq.size() != sent || ovc != 0) begin
            n_fail++;
            $display("FAIL wrap_echo got n=%0d ov=%0d exp n=%0d ov=0", tq.size(), ovc, sent);
        end
    endtask

    task automatic test_clear();
        int k;
        int bad;
        do_reset();
        send_gap(8'h1B); send_gap(8'h35); send_gap(8'h71);
        wq.delete(); wcyc.delete();
        strobe(8'h0C);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy_rise got %b exp 1", busy);
        end
        idle(1);
        strobe(8'h5A);
        idle(1);
        strobe(8'h57);
        idle(1);
        n_checks++;
        if (ovc != 1) begin
            n_fail++; $display("FAIL clear_overrun got %0d exp 1", ovc);
        end
        k = 0;
        while (busy && k < 1000) begin idle(1); k++; end
        n_checks++;
        if (busy) begin
            n_fail++; $display("FAIL clear_timeout got busy=1 exp 0");
        end
        idle(4);
        n_checks++;
        if (wq.size() != 751) begin
            n_fail++; $display("FAIL clear_count got %0d exp 751", wq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 750; i++) begin
                if (wq[i] !== {12'(i), 16'hF020}) bad++;
                if (i > 0 && wcyc[i] != wcyc[i-1] + 1) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL clear_seq got %0d bad writes exp 0", bad);
            end
            n_checks++;
            if (wq[750] !== {12'd0, 16'h355A}) begin
                n_fail++; $display("FAIL clear_pending got %h exp 000355A", wq[750]);
            end
        end
        n_checks++;
        if (cursor !== 12'd1) begin
            n_fail++; $display("FAIL clear_cursor got %0d exp 1", cursor);
        end
    endtask

    task automatic test_esc_bs();
        do_reset();
        send_gap(8'h1B); send_gap(8'h1F); send_gap(8'h42);
        n_checks++;
        if (wq.size() != 1 || wq[0] !== {12'd0, 16'h1F42}) begin
            n_fail++;
            $display("FAIL esc_attr got n=%0d w=%h exp n=1 w=0001F42", wq.size(), wq[0]);
        end
        send_gap(8'h0D);
        wq.delete();
        send_gap(8'h08);
        n_checks++;
        if (wq.size() != 0 || cursor !== 12'd0) begin
            n_fail++;
            $display("FAIL bs_col0 got n=%0d cur=%0d exp n=0 cur=0", wq.size(), cursor);
        end
        send_gap(8'h61); send_gap(8'h62); send_gap(8'h63);
        wq.delete();
        send_gap(8'h08);
        n_checks++;
        if (wq.size() != 1 || wq[0] !== {12'd2, 16'h1F20} || cursor !== 12'd2) begin
            n_fail++;
            $display("FAIL bs_col3 got n=%0d w=%h cur=%0d exp n=1 w=0021F20 cur=2",
                     wq.size(), wq[0], cursor);
        end
    endtask

    task automatic test_echo_overflow();
        logic [7:0] b [5];
        int k;
        int bad;
        do_reset();
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(32, 126));
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_gap(b[i]);
        n_checks++;
        if (ovc != 0) begin
            n_fail++; $display("FAIL echo_fill_ov got %0d exp 0", ovc);
        end
        send_gap(b[4]);
        n_checks++;
        if (ovc != 1) begin
            n_fail++; $display("FAIL echo_full_ov got %0d exp 1", ovc);
        end
        tx_busy = 1'b0;
        k = 0;
        while (tq.size() < 4 && k < 40) begin idle(1); k++; end
        idle(6);
        n_checks++;
        if (tq.size() != 4) begin
            n_fail++; $display("FAIL echo_drain got %0d exp 4", tq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                if (tq[i] !== b[i]) bad++;
                if (i > 0 && tcyc[i] - tcyc[i-1] < 3) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL echo_order got %0d bad exp 0", bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [5];
        int bad;
        do_reset();
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(32, 126));
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_gap(b[i]);
        @(posedge clk_144m);
        #1;
        rx_data  = b[4];
        rx_ready = 1'b1;
        tx_busy  = 1'b0;
        @(posedge clk_144m);
        #1;
        rx_ready = 1'b0;
        idle(30);
        n_checks++;
        if (ovc != 0) begin
            n_fail++; $display("FAIL b2b_overrun got %0d exp 0", ovc);
        end
        n_checks++;
        if (tq.size() != 5) begin
            n_fail++; $display("FAIL b2b_count got %0d exp 5", tq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 5; i++) if (tq[i] !== b[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL b2b_order got %0d bad exp 0", bad);
            end
        end
    endtask

    task automatic test_random_stream();
        int r;
        int bad;
        logic [7:0] b;
        logic err;
        logic [7:0] ctl [6];
        ctl = '{8'h01, 8'h07, 8'h09, 8'h11, 8'h7F, 8'h9A};
        do_reset();
        repeat (400) begin
            r   = $urandom_range(0, 99);
            err = 1'b0;
            if (r < 68)      b = 8'($urandom_range(32, 126));
            else if (r < 74) b = 8'h0D;
            else if (r < 80) b = 8'h0A;
            else if (r < 87) b = 8'h08;
            else if (r < 91) b = 8'h1B;
            else if (r < 95) b = ctl[$urandom_range(0, 5)];
            else begin
                b   = 8'($urandom_range(0, 255));
                err = 1'b1;
            end
            if (!err) model_byte(b);
            send_gap(b, err);
        end
        idle(12);
        n_checks++;
        if (wq.size() != ew.size()) begin
            n_fail++;
            $display("FAIL rand_wcount got %0d exp %0d", wq.size(), ew.size());
        end else begin
            bad = 0;
            for (int i = 0; i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL rand_writes got %0d bad exp 0", bad);
            end
        end
        n_checks++;
        if (cursor !== 12'(m_row * 50 + m_col)) begin
            n_fail++;
            $display("FAIL rand_cursor got %0d exp %0d", cursor, m_row * 50 + m_col);
        end
        n_checks++;
        if (tq.size() != et.size()) begin
            n_fail++;
            $display("FAIL rand_ecount got %0d exp %0d", tq.size(), et.size());
        end else begin
            bad = 0;
            for (int i = 0; i < et.size(); i++) if (tq[i] !== et[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL rand_echo got %0d bad exp 0", bad);
            end
        end
        n_checks++;
        if (ovc != 0) begin
            n_fail++; $display("FAIL rand_overrun got %0d exp 0", ovc);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        send_gap(8'h1B); send_gap(8'h77);
        strobe(8'h0C);
        idle(10);
        n_checks++;
        if (busy !== 1'b1 || ram_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL rmc_pre got busy=%b ce=%b exp 1/1", busy, ram_ce);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ram_ce !== 1'b0 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmc_async got busy=%b ce=%b txr=%b exp 0/0/0",
                     busy, ram_ce, tx_ready);
        end
        idle(2);
        reset = 1'b1;
        idle(1);
        n_checks++;
        if (cursor !== 12'd0) begin
            n_fail++; $display("FAIL rmc_cursor got %0d exp 0", cursor);
        end
        wq.delete();
        send_gap(8'h43);
        n_checks++;
        if (wq.size() != 1 || wq[0] !== {12'd0, 16'hF043}) begin
            n_fail++;
            $display("FAIL rmc_attr got n=%0d w=%h exp n=1 w=000F043", wq.size(), wq[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_wrap();
        test_clear();
        test_esc_bs();
        test_echo_overflow();
        test_back_to_back();
        test_random_stream();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
